// File: rtl/alu_selftest_sequencer.sv
// ALU self-test sequencer: drives LFSR-generated operand pairs through eight ALU ops
// and checks ALUResult/Zero against a built-in golden model.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for Start after reset
// S_DRIVE | vector presented on A/B/ALUControl, ALU settling
// S_CHECK | compare ALU outputs, update fail registers, load next vector
// S_DONE  | run complete, results held until Start or Reset
module alu_selftest_sequencer #(
    parameter int          NUM_PAIRS = 4,
    parameter logic [31:0] SEED      = 32'h1234_5678
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    output logic [5:0]  ALUControl,
    output logic [31:0] A,
    output logic [31:0] B,
    input  logic [31:0] ALUResult,
    input  logic        Zero,
    output logic        Busy,
    output logic        Done,
    output logic        Pass,
    output logic [15:0] FailCount,
    output logic [10:0] FailIndex,
    output logic [31:0] FailResult
);
    localparam logic [31:0] SEED_EFF  = (SEED == 32'h0) ? 32'h0000_0001 : SEED;
    localparam logic [7:0]  LAST_PAIR = 8'(NUM_PAIRS - 1);

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_CHECK, S_DONE} state_t;

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return {1'b0, x[31:1]} ^ (x[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    function automatic logic [5:0] op_code(input logic [2:0] op);
        case (op)
            3'd0:    return 6'b100000;
            3'd1:    return 6'b100010;
            3'd2:    return 6'b100100;
            3'd3:    return 6'b100101;
            3'd4:    return 6'b100110;
            3'd5:    return 6'b000000;
            3'd6:    return 6'b000010;
            default: return 6'b011000;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  pair_q, pair_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] lfsr_q, lfsr_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [5:0]  ctl_q, ctl_d;
    logic        busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [15:0] fail_count_q, fail_count_d;
    logic [10:0] fail_index_q, fail_index_d;
    logic [31:0] fail_result_q, fail_result_d;

    logic [31:0] lfsr_a, lfsr_b, exp_result;
    logic        vec_fail, last_vec;

    assign lfsr_a = lfsr_step(lfsr_q);
    assign lfsr_b = lfsr_step(lfsr_a);

    always_comb begin
        case (op_q)
            3'd0:    exp_result = a_q + b_q;
            3'd1:    exp_result = a_q - b_q;
            3'd2:    exp_result = a_q & b_q;
            3'd3:    exp_result = a_q | b_q;
            3'd4:    exp_result = a_q ^ b_q;
            3'd5:    exp_result = a_q << b_q[4:0];
            3'd6:    exp_result = a_q >> b_q[4:0];
            default: exp_result = a_q * b_q;
        endcase
    end

    assign vec_fail = (ALUResult != exp_result) || (Zero != (exp_result == 32'h0));
    assign last_vec = (pair_q == LAST_PAIR) && (op_q == 3'd7);

    always_comb begin
        state_d       = state_q;
        pair_d        = pair_q;
        op_d          = op_q;
        lfsr_d        = lfsr_q;
        a_d           = a_q;
        b_d           = b_q;
        ctl_d         = ctl_q;
        busy_d        = busy_q;
        done_d        = done_q;
        pass_d        = pass_q;
        fail_count_d  = fail_count_q;
        fail_index_d  = fail_index_q;
        fail_result_d = fail_result_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    state_d       = S_DRIVE;
                    pair_d        = 8'd0;
                    op_d          = 3'd0;
                    lfsr_d        = SEED_EFF;
                    a_d           = SEED_EFF;
                    b_d           = SEED_EFF;
                    ctl_d         = op_code(3'd0);
                    busy_d        = 1'b1;
                    done_d        = 1'b0;
                    pass_d        = 1'b0;
                    fail_count_d  = 16'h0;
                    fail_index_d  = 11'h0;
                    fail_result_d = 32'h0;
                end
            end
            S_DRIVE: state_d = S_CHECK;
            S_CHECK: begin
                // A saturated count never returns to zero, so zero means "no failure yet".
                if (vec_fail) begin
                    if (fail_count_q != 16'hFFFF) fail_count_d = fail_count_q + 16'd1;
                    if (fail_count_q == 16'h0) begin
                        fail_index_d  = {pair_q, op_q};
                        fail_result_d = ALUResult;
                    end
                end
                if (last_vec) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (fail_count_d == 16'h0);
                end else begin
                    state_d = S_DRIVE;
                    op_d    = op_q + 3'd1;
                    ctl_d   = op_code(op_q + 3'd1);
                    if (op_q == 3'd7) begin
                        pair_d = pair_q + 8'd1;
                        a_d    = lfsr_a;
                        b_d    = lfsr_b;
                        lfsr_d = lfsr_b;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= S_IDLE;
            pair_q        <= 8'd0;
            op_q          <= 3'd0;
            lfsr_q        <= SEED_EFF;
            a_q           <= 32'h0;
            b_q           <= 32'h0;
            ctl_q         <= 6'h0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            fail_count_q  <= 16'h0;
            fail_index_q  <= 11'h0;
            fail_result_q <= 32'h0;
        end else begin
            state_q       <= state_d;
            pair_q        <= pair_d;
            op_q          <= op_d;
            lfsr_q        <= lfsr_d;
            a_q           <= a_d;
            b_q           <= b_d;
            ctl_q         <= ctl_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            fail_count_q  <= fail_count_d;
            fail_index_q  <= fail_index_d;
            fail_result_q <= fail_result_d;
        end
    end

    assign ALUControl = ctl_q;
    assign A          = a_q;
    assign B          = b_q;
    assign Busy       = busy_q;
    assign Done       = done_q;
    assign Pass       = pass_q;
    assign FailCount  = fail_count_q;
    assign FailIndex  = fail_index_q;
    assign FailResult = fail_result_q;
endmodule

// File: tb/tb_alu_selftest_sequencer.sv
// Bench for alu_selftest_sequencer: an ALU model with injectable faults and a
// run-level reference model predicting the sequencer's verdict.
module tb_alu_selftest_sequencer;
    localparam logic [31:0] SEED0  = 32'h1234_5678;
    localparam int          PAIRS0 = 4;
    localparam logic [31:0] POLY   = 32'h8020_0003;

    logic [5:0] codes [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                              6'b100110, 6'b000000, 6'b000010, 6'b011000};

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        reset0, start0, zero0, busy0, done0, pass0;
    logic [5:0]  ctl0;
    logic [31:0] a0, b0, res0, fr0;
    logic [15:0] fc0;
    logic [10:0] fi0;

    logic        reset1, start1, zero1, busy1, done1, pass1;
    logic [5:0]  ctl1;
    logic [31:0] a1, b1, res1, fr1;
    logic [15:0] fc1;
    logic [10:0] fi1;

    int         fmode = 0;
    logic [5:0] fctl  = 6'b100000;
    int         n_checks = 0;
    int         n_err = 0;

    // fmode: 0 correct, 1 result+1 for opcode fctl, 2 Zero stuck at 0
    function automatic logic [31:0] alu_model(input logic [5:0] c, input logic [31:0] a,
                                              input logic [31:0] b, input int fm,
                                              input logic [5:0] fc);
        logic [31:0] r;
        case (c)
            6'b100000: r = a + b;
            6'b100010: r = a - b;
            6'b100100: r = a & b;
            6'b100101: r = a | b;
            6'b100110: r = a ^ b;
            6'b000000: r = a << b[4:0];
            6'b000010: r = a >> b[4:0];
            6'b011000: r = a * b;
            default:   r = 32'hDEAD_BEEF;
        endcase
        if (fm == 1 && c == fc) r = r + 32'd1;
        return r;
    endfunction

    always_comb begin
        res0  = alu_model(ctl0, a0, b0, fmode, fctl);
        zero0 = (fmode == 2) ? 1'b0 : (res0 == 32'h0);
    end
    assign res1  = alu_model(ctl1, a1, b1, 0, 6'h0);
    assign zero1 = (res1 == 32'h0);

    alu_selftest_sequencer #(.NUM_PAIRS(PAIRS0), .SEED(SEED0)) u_dut0 (
        .Clk(Clk), .Reset(reset0), .Start(start0), .ALUControl(ctl0), .A(a0), .B(b0),
        .ALUResult(res0), .Zero(zero0), .Busy(busy0), .Done(done0), .Pass(pass0),
        .FailCount(fc0), .FailIndex(fi0), .FailResult(fr0));

    alu_selftest_sequencer #(.NUM_PAIRS(1), .SEED(32'h0)) u_dut1 (
        .Clk(Clk), .Reset(reset1), .Start(start1), .ALUControl(ctl1), .A(a1), .B(b1),
        .ALUResult(res1), .Zero(zero1), .Busy(busy1), .Done(done1), .Pass(pass1),
        .FailCount(fc1), .FailIndex(fi1), .FailResult(fr1));

    function automatic logic [31:0] lstep(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? POLY : 32'h0);
    endfunction

    function automatic logic [31:0] golden(input int op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] w;
        case (op)
            0:       w = {32'h0, a} + {32'h0, b};
            1:       w = {32'h0, a} + {32'h0, ~b} + 64'd1;
            2:       w = {32'h0, a & b};
            3:       w = {32'h0, a | b};
            4:       w = {32'h0, a ^ b};
            5:       w = {32'h0, a} * (64'd1 << b[4:0]);
            6:       w = {32'h0, a} / (64'd1 << b[4:0]);
            default: w = {32'h0, a} * {32'h0, b};
        endcase
        return w[31:0];
    endfunction

    // Predicts the verdict of one full run on dut0 with the given ALU fault.
    task automatic model_run(input int fm, input logic [5:0] fc, output logic [15:0] cnt,
                             output logic [10:0] idx, output logic [31:0] res);
        logic [31:0] x, a, b, g, r;
        logic        z;
        cnt = 0; idx = 0; res = 0;
        x = (SEED0 == 0) ? 32'h1 : SEED0;
        for (int p = 0; p < PAIRS0; p++) begin
            if (p == 0) begin
                a = x; b = x;
            end else begin
                a = lstep(x); b = lstep(a); x = b;
            end
            for (int op = 0; op < 8; op++) begin
                g = golden(op, a, b);
                r = alu_model(codes[op], a, b, fm, fc);
                z = (fm == 2) ? 1'b0 : (r == 0);
                if (r !== g || z !== (g == 0)) begin
                    if (cnt == 0) begin
                        idx = {8'(p), 3'(op)};
                        res = r;
                    end
                    cnt = cnt + 1;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic start_run();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        chk("start_busy", 32'(busy0), 32'd1);
        chk("start_done", 32'(done0), 32'd0);
        chk("start_a", a0, SEED0);
        chk("start_b", b0, SEED0);
        chk("start_ctl", 32'(ctl0), 32'(codes[0]));
        chk("start_fc", 32'(fc0), 32'd0);
    endtask

    task automatic finish_run(input int poke, input string tag);
        logic [15:0] ecnt;
        logic [10:0] eidx;
        logic [31:0] eres;
        int cyc;
        model_run(fmode, fctl, ecnt, eidx, eres);
        cyc = 0;
        while (!done0 && cyc < 300) begin
            tick();
            cyc++;
            start0 = (poke != 0 && cyc == poke);
        end
        start0 = 1'b0;
        chk({tag, "_cycles"}, 32'(cyc), 32'(16 * PAIRS0));
        chk({tag, "_done"}, 32'(done0), 32'd1);
        chk({tag, "_busy"}, 32'(busy0), 32'd0);
        chk({tag, "_pass"}, 32'(pass0), 32'(ecnt == 0));
        chk({tag, "_fc"}, 32'(fc0), 32'(ecnt));
        chk({tag, "_fi"}, 32'(fi0), 32'(eidx));
        chk({tag, "_fr"}, fr0, eres);
    endtask

    initial begin
        int cyc;
        reset0 = 1'b1; start0 = 1'b0; reset1 = 1'b1; start1 = 1'b0;
        tick(); tick();
        reset0 = 1'b0; reset1 = 1'b0;
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_pass", 32'(pass0), 32'd0);
        chk("rst_a", a0, 32'h0);
        chk("rst_ctl", 32'(ctl0), 32'h0);
        chk("rst_fc", 32'(fc0), 32'h0);

        fmode = 0;
        start_run();
        finish_run(0, "good");

        fmode = 1; fctl = 6'b100000;
        start_run();
        finish_run(0, "add1");
        chk("add1_fc_const", 32'(fc0), 32'd4);
        chk("add1_fr_const", fr0, 32'h2468_ACF1);

        fmode = 2;
        start_run();
        finish_run(0, "zstuck");
        chk("zstuck_fi_const", 32'(fi0), 32'h001);

        fmode = 0;
        start_run();
        finish_run(10, "poke10");

        // Reset in mid-run
        start_run();
        for (int i = 1; i < 20; i++) tick();
        reset0 = 1'b1;
        tick();
        reset0 = 1'b0;
        chk("midrst_busy", 32'(busy0), 32'd0);
        chk("midrst_done", 32'(done0), 32'd0);
        chk("midrst_a", a0, 32'h0);
        chk("midrst_b", b0, 32'h0);
        chk("midrst_ctl", 32'(ctl0), 32'h0);
        tick();
        chk("midrst_idle", 32'(busy0), 32'd0);
        start_run();
        finish_run(0, "after_rst");

        for (int it = 0; it < 6; it++) begin
            fmode = $urandom_range(0, 2);
            fctl  = codes[$urandom_range(0, 7)];
            start_run();
            finish_run(($urandom_range(0, 1) == 1) ? $urandom_range(1, 60) : 0, "rand");
        end

        // SEED=0, one pair: operands collapse to 1
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        cyc = 0;
        while (cyc < 16) begin
            if (cyc % 2 == 0) begin
                chk("s0_ctl", 32'(ctl1), 32'(codes[cyc / 2]));
                chk("s0_a", a1, 32'h1);
                chk("s0_b", b1, 32'h1);
                if (cyc == 10) chk("s0_sll", res1, 32'h2);
                if (cyc == 12) chk("s0_srl", res1, 32'h0);
                if (cyc == 12) chk("s0_srl_zero", 32'(zero1), 32'd1);
                if (cyc == 14) chk("s0_mul", res1, 32'h1);
            end
            chk("s0_not_done", 32'(done1), 32'd0);
            tick();
            cyc++;
        end
        chk("s0_done", 32'(done1), 32'd1);
        chk("s0_pass", 32'(pass1), 32'd1);
        chk("s0_fc", 32'(fc1), 32'd0);
        chk("s0_busy", 32'(busy1), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
